// File: rtl/edge_detection_pkg.sv
// Shared types and helpers for the edge detection pipeline.
// Holds the line-buffer controller state encoding and slot rotation.
package edge_detection_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_DONE
    } ctrl_state_t;

    localparam int SLOT_BITS = 2;

    localparam int DEFAULT_FRAME_COLUMNS = 640;
    localparam int DEFAULT_FRAME_ROWS    = 480;

    function automatic logic [SLOT_BITS-1:0] next_slot(
        input logic [SLOT_BITS-1:0] slot
    );
        return (slot == 2'd2) ? 2'd0 : slot + 2'd1;
    endfunction

endpackage

// File: rtl/matrix3_ready_align.sv
// Delays the matrix-ready strobe and its coordinates by the buffer
// read latency; coordinates hold their last value between strobes.
module matrix3_ready_align #(
    parameter int P_READ_LATENCY = 1,
    parameter int P_COLUMN_BITS  = 10,
    parameter int P_ROW_BITS     = 9
) (
    input  logic                     I_CLK,
    input  logic                     I_RESET,
    input  logic                     I_READY,
    input  logic                     I_FRAME_DONE,
    input  logic [P_COLUMN_BITS-1:0] I_COLUMN,
    input  logic [P_ROW_BITS-1:0]    I_ROW,
    output logic                     O_READY,
    output logic                     O_FRAME_DONE,
    output logic [P_COLUMN_BITS-1:0] O_COLUMN,
    output logic [P_ROW_BITS-1:0]    O_ROW
);

    logic [P_READ_LATENCY-1:0] rdy_q;
    logic [P_READ_LATENCY-1:0] done_q;
    logic [P_COLUMN_BITS-1:0]  col_q [P_READ_LATENCY];
    logic [P_ROW_BITS-1:0]     row_q [P_READ_LATENCY];

    // Shift strobes every cycle; coordinates move only with a strobe.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            rdy_q  <= '0;
            done_q <= '0;
            for (int i = 0; i < P_READ_LATENCY; i++) begin
                col_q[i] <= '0;
                row_q[i] <= '0;
            end
        end else begin
            rdy_q[0]  <= I_READY;
            done_q[0] <= I_READY && I_FRAME_DONE;
            if (I_READY) begin
                col_q[0] <= I_COLUMN;
                row_q[0] <= I_ROW;
            end
            for (int i = 1; i < P_READ_LATENCY; i++) begin
                rdy_q[i]  <= rdy_q[i-1];
                done_q[i] <= done_q[i-1];
                if (rdy_q[i-1]) begin
                    col_q[i] <= col_q[i-1];
                    row_q[i] <= row_q[i-1];
                end
            end
        end
    end

    assign O_READY      = rdy_q[P_READ_LATENCY-1];
    assign O_FRAME_DONE = done_q[P_READ_LATENCY-1];
    assign O_COLUMN     = col_q[P_READ_LATENCY-1];
    assign O_ROW        = row_q[P_READ_LATENCY-1];

endmodule

// File: rtl/frame_buffer_matrix3_controller.sv
// Sequences the 3-row line buffer: writes each pixel, then issues one
// 3x3 neighbourhood read per interior pixel and flags matrix readiness.
module frame_buffer_matrix3_controller
    import edge_detection_pkg::*;
#(
    parameter int P_FRAME_COLUMNS     = DEFAULT_FRAME_COLUMNS,
    parameter int P_FRAME_ROWS        = DEFAULT_FRAME_ROWS,
    parameter int P_PIXEL_DEPTH       = 8,
    parameter int P_READ_LATENCY      = 1,
    parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
    parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS)
) (
    input  logic                           I_CLK,
    input  logic                           I_RESET,
    input  logic                           I_FRAME_START,
    input  logic                           I_PIXEL_VALID,
    input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
    output logic [P_FRAME_COLUMN_BITS-1:0] O_BUF_COLUMN,
    output logic [SLOT_BITS-1:0]           O_BUF_ROW,
    output logic [P_PIXEL_DEPTH-1:0]       O_BUF_PIXEL,
    output logic                           O_BUF_WRITE_ENABLE,
    output logic                           O_BUF_READ_ENABLE,
    output logic [P_FRAME_COLUMN_BITS-1:0] O_MATRIX_COLUMN,
    output logic [P_FRAME_ROW_BITS-1:0]    O_MATRIX_ROW,
    output logic                           O_MATRIX_READY,
    output logic                           O_FRAME_DONE,
    output logic                           O_OVERRUN
);

    localparam int CB = P_FRAME_COLUMN_BITS;
    localparam int RB = P_FRAME_ROW_BITS;

    localparam logic [CB-1:0] COL_LAST = CB'(P_FRAME_COLUMNS - 1);
    localparam logic [CB-1:0] COL_ONE  = CB'(1);
    localparam logic [CB-1:0] COL_TWO  = CB'(2);
    localparam logic [RB-1:0] ROW_LAST = RB'(P_FRAME_ROWS - 1);
    localparam logic [RB-1:0] ROW_ONE  = RB'(1);
    localparam logic [RB-1:0] ROW_TWO  = RB'(2);

    ctrl_state_t state_q, state_d, eff_state;

    logic [CB-1:0]        col_q, eff_col;
    logic [RB-1:0]        row_q, eff_row;
    logic [SLOT_BITS-1:0] slot_q, eff_slot;

    logic take, drop, accept;
    logic col_last, row_last, pix_last, want_read;

    logic                 rd_pend_q;
    logic [CB-1:0]        rd_col_q, rd_mcol_q;
    logic [RB-1:0]        rd_mrow_q;
    logic [SLOT_BITS-1:0] rd_slot_q;
    logic                 rd_last_q;

    logic [CB-1:0] iss_mcol_q;
    logic [RB-1:0] iss_mrow_q;
    logic          iss_last_q;

    // Frame start overrides position so a coincident pixel lands at (0,0).
    always_comb begin
        eff_state = state_q;
        eff_col   = col_q;
        eff_row   = row_q;
        eff_slot  = slot_q;
        if (I_FRAME_START) begin
            eff_state = ST_FILL;
            eff_col   = '0;
            eff_row   = '0;
            eff_slot  = '0;
        end
        take = I_PIXEL_VALID
            && (eff_state == ST_FILL || eff_state == ST_STREAM);
        drop      = take && rd_pend_q;
        accept    = take && !rd_pend_q;
        col_last  = (eff_col == COL_LAST);
        row_last  = (eff_row == ROW_LAST);
        pix_last  = accept && col_last && row_last;
        want_read = accept && (eff_state == ST_STREAM)
            && (eff_col >= COL_TWO);
    end

    // Next state: last pixel ends the frame, entering row 2 starts reads.
    always_comb begin
        state_d = eff_state;
        unique case (1'b1)
            pix_last:
                state_d = ST_DONE;
            accept && col_last && (eff_row == ROW_ONE):
                state_d = ST_STREAM;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Raster position and row-slot rotation.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            col_q  <= '0;
            row_q  <= '0;
            slot_q <= '0;
        end else if (accept) begin
            unique case (1'b1)
                col_last && row_last: begin
                    col_q  <= '0;
                    row_q  <= '0;
                    slot_q <= '0;
                end
                col_last && !row_last: begin
                    col_q  <= '0;
                    row_q  <= eff_row + ROW_ONE;
                    slot_q <= next_slot(eff_slot);
                end
                default: begin
                    col_q  <= eff_col + COL_ONE;
                    row_q  <= eff_row;
                    slot_q <= eff_slot;
                end
            endcase
        end else begin
            col_q  <= eff_col;
            row_q  <= eff_row;
            slot_q <= eff_slot;
        end
    end

    // Latch the read request one cycle behind its write.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            rd_pend_q <= 1'b0;
            rd_col_q  <= '0;
            rd_mcol_q <= '0;
            rd_mrow_q <= '0;
            rd_slot_q <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_pend_q <= want_read;
            if (want_read) begin
                rd_col_q  <= eff_col - COL_ONE;
                rd_mcol_q <= eff_col - COL_TWO;
                rd_mrow_q <= eff_row - ROW_TWO;
                rd_slot_q <= eff_slot;
                rd_last_q <= pix_last;
            end
        end
    end

    // Buffer port: write and read never overlap since a colliding
    // pixel is dropped.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            O_BUF_WRITE_ENABLE <= 1'b0;
            O_BUF_READ_ENABLE  <= 1'b0;
            O_BUF_COLUMN       <= '0;
            O_BUF_ROW          <= '0;
            O_BUF_PIXEL        <= '0;
            iss_mcol_q         <= '0;
            iss_mrow_q         <= '0;
            iss_last_q         <= 1'b0;
        end else begin
            O_BUF_WRITE_ENABLE <= accept;
            O_BUF_READ_ENABLE  <= rd_pend_q;
            unique case (1'b1)
                accept: begin
                    O_BUF_COLUMN <= eff_col;
                    O_BUF_ROW    <= eff_slot;
                    O_BUF_PIXEL  <= I_PIXEL;
                end
                rd_pend_q: begin
                    O_BUF_COLUMN <= rd_col_q;
                    O_BUF_ROW    <= rd_slot_q;
                end
                default: ;
            endcase
            if (rd_pend_q) begin
                iss_mcol_q <= rd_mcol_q;
                iss_mrow_q <= rd_mrow_q;
                iss_last_q <= rd_last_q;
            end
        end
    end

    // Sticky flag for pixels lost to spacing violations.
    always_ff @(posedge I_CLK) begin
        if (I_RESET)   O_OVERRUN <= 1'b0;
        else if (drop) O_OVERRUN <= 1'b1;
    end

    matrix3_ready_align #(
        .P_READ_LATENCY (P_READ_LATENCY),
        .P_COLUMN_BITS  (CB),
        .P_ROW_BITS     (RB)
    ) u_ready_align (
        .I_CLK        (I_CLK),
        .I_RESET      (I_RESET),
        .I_READY      (O_BUF_READ_ENABLE),
        .I_FRAME_DONE (iss_last_q),
        .I_COLUMN     (iss_mcol_q),
        .I_ROW        (iss_mrow_q),
        .O_READY      (O_MATRIX_READY),
        .O_FRAME_DONE (O_FRAME_DONE),
        .O_COLUMN     (O_MATRIX_COLUMN),
        .O_ROW        (O_MATRIX_ROW)
    );

endmodule

// File: tb/tb_frame_buffer_matrix3_controller.sv
// Scoreboard bench for the 3-row line buffer controller.
// Driver queues expected buffer events; a negedge monitor checks them.
module tb_frame_buffer_matrix3_controller;

    localparam int C   = 8;
    localparam int R   = 6;
    localparam int LAT = 1;
    localparam int CB  = $clog2(C);
    localparam int RB  = $clog2(R);

    logic          clk = 1'b0;
    logic          I_RESET;
    logic          I_FRAME_START;
    logic          I_PIXEL_VALID;
    logic [7:0]    I_PIXEL;
    logic [CB-1:0] O_BUF_COLUMN;
    logic [1:0]    O_BUF_ROW;
    logic [7:0]    O_BUF_PIXEL;
    logic          O_BUF_WRITE_ENABLE;
    logic          O_BUF_READ_ENABLE;
    logic [CB-1:0] O_MATRIX_COLUMN;
    logic [RB-1:0] O_MATRIX_ROW;
    logic          O_MATRIX_READY;
    logic          O_FRAME_DONE;
    logic          O_OVERRUN;

    frame_buffer_matrix3_controller #(
        .P_FRAME_COLUMNS (C),
        .P_FRAME_ROWS    (R),
        .P_PIXEL_DEPTH   (8),
        .P_READ_LATENCY  (LAT)
    ) dut (
        .I_CLK              (clk),
        .I_RESET            (I_RESET),
        .I_FRAME_START      (I_FRAME_START),
        .I_PIXEL_VALID      (I_PIXEL_VALID),
        .I_PIXEL            (I_PIXEL),
        .O_BUF_COLUMN       (O_BUF_COLUMN),
        .O_BUF_ROW          (O_BUF_ROW),
        .O_BUF_PIXEL        (O_BUF_PIXEL),
        .O_BUF_WRITE_ENABLE (O_BUF_WRITE_ENABLE),
        .O_BUF_READ_ENABLE  (O_BUF_READ_ENABLE),
        .O_MATRIX_COLUMN    (O_MATRIX_COLUMN),
        .O_MATRIX_ROW       (O_MATRIX_ROW),
        .O_MATRIX_READY     (O_MATRIX_READY),
        .O_FRAME_DONE       (O_FRAME_DONE),
        .O_OVERRUN          (O_OVERRUN)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int col;
        int row;
        int data;
        bit last;
    } ev_t;

    ev_t wq[$];
    ev_t rq[$];
    ev_t yq[$];
    ev_t mw, mr, my;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int nw = 0, nr = 0, ny = 0, nd = 0;
    int first_col = -1, first_row = -1;

    int m_state = 0;
    int m_col = 0, m_row = 0, m_slot = 0;
    int m_last_rd = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_col"}, int'(O_BUF_COLUMN), 0);
        check({nm, "_slot"}, int'(O_BUF_ROW), 0);
        check({nm, "_pix"}, int'(O_BUF_PIXEL), 0);
        check({nm, "_we"}, int'(O_BUF_WRITE_ENABLE), 0);
        check({nm, "_re"}, int'(O_BUF_READ_ENABLE), 0);
        check({nm, "_mcol"}, int'(O_MATRIX_COLUMN), 0);
        check({nm, "_mrow"}, int'(O_MATRIX_ROW), 0);
        check({nm, "_rdy"}, int'(O_MATRIX_READY), 0);
        check({nm, "_done"}, int'(O_FRAME_DONE), 0);
        check({nm, "_ovr"}, int'(O_OVERRUN), 0);
    endtask

    task automatic model_reset();
        wq.delete();
        rq.delete();
        yq.delete();
        m_state = 0;
        m_col = 0;
        m_row = 0;
        m_slot = 0;
        m_last_rd = -10;
    endtask

    // Drive one cycle of inputs and queue the expected responses.
    task automatic drive(input bit fs, input bit v,
                         input logic [7:0] px, output bit rd);
        bit lst;
        rd = 0;
        I_FRAME_START = fs;
        I_PIXEL_VALID = v;
        I_PIXEL = px;
        if (fs) begin
            m_col = 0;
            m_row = 0;
            m_slot = 0;
            m_state = 1;
        end
        if (v && (m_state == 1 || m_state == 2)
            && m_last_rd != cyc - 1) begin
            lst = (m_col == C - 1) && (m_row == R - 1);
            wq.push_back('{cyc + 1, m_col, m_slot, int'(px), 1'b0});
            if (m_state == 2 && m_col >= 2) begin
                rd = 1;
                m_last_rd = cyc;
                rq.push_back('{cyc + 2, m_col - 1, m_slot, 0, 1'b0});
                yq.push_back('{cyc + 2 + LAT, m_col - 2, m_row - 2,
                               0, lst});
            end
            if (m_col == C - 1) begin
                m_col = 0;
                if (m_row == R - 1) begin
                    m_row = 0;
                    m_slot = 0;
                    m_state = 3;
                end else begin
                    m_row++;
                    m_slot = (m_slot + 1) % 3;
                    if (m_row == 2) m_state = 2;
                end
            end else begin
                m_col++;
            end
        end
        tick();
        I_FRAME_START = 0;
        I_PIXEL_VALID = 0;
    endtask

    task automatic send_gap(input bit fs, input logic [7:0] px);
        bit rd;
        drive(fs, 1'b1, px, rd);
        tick();
        tick();
    endtask

    // Monitor: pop expected events whenever the DUT presents one.
    always @(negedge clk) begin
        if (wq.size() > 0 && wq[0].cyc < cyc) begin
            mw = wq.pop_front();
            tests++; fails++;
            $display("FAIL wr_missing: no write, expected col %0d at cyc %0d",
                     mw.col, mw.cyc);
        end
        if (rq.size() > 0 && rq[0].cyc < cyc) begin
            mr = rq.pop_front();
            tests++; fails++;
            $display("FAIL rd_missing: no read, expected col %0d at cyc %0d",
                     mr.col, mr.cyc);
        end
        if (yq.size() > 0 && yq[0].cyc < cyc) begin
            my = yq.pop_front();
            tests++; fails++;
            $display("FAIL rdy_missing: no ready, expected (%0d,%0d) at cyc %0d",
                     my.col, my.row, my.cyc);
        end
        if (O_BUF_WRITE_ENABLE && O_BUF_READ_ENABLE) begin
            tests++; fails++;
            $display("FAIL wr_rd_overlap: both enables 1, required not both");
        end
        if (O_BUF_WRITE_ENABLE) begin
            nw++;
            tests++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL wr_spurious: write col %0d at cyc %0d, none expected",
                         O_BUF_COLUMN, cyc);
            end else begin
                mw = wq.pop_front();
                if (mw.cyc != cyc || mw.col != int'(O_BUF_COLUMN)
                    || mw.row != int'(O_BUF_ROW)
                    || mw.data != int'(O_BUF_PIXEL)) begin
                    fails++;
                    $display("FAIL wr: got cyc %0d col %0d slot %0d px %0h, expected cyc %0d col %0d slot %0d px %0h",
                             cyc, O_BUF_COLUMN, O_BUF_ROW, O_BUF_PIXEL,
                             mw.cyc, mw.col, mw.row, mw.data);
                end
            end
        end
        if (O_BUF_READ_ENABLE) begin
            nr++;
            tests++;
            if (rq.size() == 0) begin
                fails++;
                $display("FAIL rd_spurious: read col %0d at cyc %0d, none expected",
                         O_BUF_COLUMN, cyc);
            end else begin
                mr = rq.pop_front();
                if (mr.cyc != cyc || mr.col != int'(O_BUF_COLUMN)
                    || mr.row != int'(O_BUF_ROW)) begin
                    fails++;
                    $display("FAIL rd: got cyc %0d col %0d slot %0d, expected cyc %0d col %0d slot %0d",
                             cyc, O_BUF_COLUMN, O_BUF_ROW,
                             mr.cyc, mr.col, mr.row);
                end
            end
        end
        if (O_FRAME_DONE) nd++;
        if (O_FRAME_DONE && !O_MATRIX_READY) begin
            tests++; fails++;
            $display("FAIL done_alone: frame_done 1 with ready 0, required ready 1");
        end
        if (O_MATRIX_READY) begin
            if (ny == 0) begin
                first_col = int'(O_MATRIX_COLUMN);
                first_row = int'(O_MATRIX_ROW);
            end
            ny++;
            tests++;
            if (yq.size() == 0) begin
                fails++;
                $display("FAIL rdy_spurious: ready (%0d,%0d) at cyc %0d, none expected",
                         O_MATRIX_COLUMN, O_MATRIX_ROW, cyc);
            end else begin
                my = yq.pop_front();
                if (my.cyc != cyc || my.col != int'(O_MATRIX_COLUMN)
                    || my.row != int'(O_MATRIX_ROW)
                    || my.last != O_FRAME_DONE) begin
                    fails++;
                    $display("FAIL rdy: got cyc %0d (%0d,%0d) done %0d, expected cyc %0d (%0d,%0d) done %0d",
                             cyc, O_MATRIX_COLUMN, O_MATRIX_ROW, O_FRAME_DONE,
                             my.cyc, my.col, my.row, my.last);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rd;
        I_RESET = 1;
        I_FRAME_START = 0;
        I_PIXEL_VALID = 0;
        I_PIXEL = 0;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        tick();
        I_RESET = 0;

        // IDLE ignores pixels.
        send_gap(1'b0, 8'h11);
        send_gap(1'b0, 8'h22);
        check("idle_writes", nw, 0);

        // Frame A, with hand-checked timing at pixel (2,2).
        drive(1'b1, 1'b0, 8'h00, rd);
        tick();
        nw = 0; nr = 0; ny = 0; nd = 0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (r == 2 && c == 2) begin
                    drive(1'b0, 1'b1, 8'hA5, rd);
                    @(negedge clk);
                    check("a5_we", int'(O_BUF_WRITE_ENABLE), 1);
                    check("a5_wcol", int'(O_BUF_COLUMN), 2);
                    check("a5_wslot", int'(O_BUF_ROW), 2);
                    check("a5_data", int'(O_BUF_PIXEL), 8'hA5);
                    @(negedge clk);
                    check("a5_re", int'(O_BUF_READ_ENABLE), 1);
                    check("a5_rcol", int'(O_BUF_COLUMN), 1);
                    check("a5_rslot", int'(O_BUF_ROW), 2);
                    @(negedge clk);
                    check("a5_rdy", int'(O_MATRIX_READY), 1);
                    check("a5_mcol", int'(O_MATRIX_COLUMN), 0);
                    check("a5_mrow", int'(O_MATRIX_ROW), 0);
                    tick();
                end else begin
                    send_gap(1'b0, 8'(r * 8 + c));
                end
            end
        end
        repeat (6) tick();
        check("a_writes", nw, 48);
        check("a_reads", nr, 24);
        check("a_readys", ny, 24);
        check("a_done", nd, 1);
        check("a_hold_col", int'(O_MATRIX_COLUMN), 5);
        check("a_hold_row", int'(O_MATRIX_ROW), 3);

        // DONE ignores pixels.
        send_gap(1'b0, 8'h33);
        check("done_writes", nw, 48);

        // Frame B: restart mid-row 3 right behind a read.
        drive(1'b1, 1'b0, 8'h00, rd);
        tick();
        for (int i = 0; i < 26; i++) send_gap(1'b0, 8'(i + 64));
        drive(1'b0, 1'b1, 8'h7F, rd);
        drive(1'b1, 1'b0, 8'h00, rd);
        repeat (4) tick();

        // Frame C begins with start and pixel together.
        nw = 0; nr = 0; ny = 0; nd = 0;
        send_gap(1'b1, 8'hC0);
        for (int i = 1; i < C * R; i++) send_gap(1'b0, 8'(i + 128));
        repeat (6) tick();
        check("c_writes", nw, 48);
        check("c_reads", nr, 24);
        check("c_readys", ny, 24);
        check("c_done", nd, 1);
        check("c_first_col", first_col, 0);
        check("c_first_row", first_row, 0);

        // Frame D: back-to-back pixels in STREAM overrun.
        check("pre_ovr", int'(O_OVERRUN), 0);
        send_gap(1'b1, 8'hD0);
        for (int i = 1; i < 2 * C; i++) send_gap(1'b0, 8'(i + 200));
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'(i + 16), rd);
        repeat (4) tick();
        check("ovr_set", int'(O_OVERRUN), 1);
        repeat (10) tick();
        check("ovr_held", int'(O_OVERRUN), 1);

        // Reset one cycle behind a read enable.
        rd = 0;
        for (int i = 0; i < 10 && !rd; i++) begin
            drive(1'b0, 1'b1, 8'(i + 40), rd);
            if (!rd) begin
                tick();
                tick();
            end
        end
        check("found_read", int'(rd), 1);
        tick();
        I_RESET = 1;
        tick();
        I_RESET = 0;
        model_reset();
        @(negedge clk);
        check_zero("mid_reset");
        tick();
        send_gap(1'b0, 8'h44);
        send_gap(1'b0, 8'h55);

        // Resume after reset.
        send_gap(1'b1, 8'hE0);
        for (int i = 1; i < 20; i++) send_gap(1'b0, 8'(i + 224));
        repeat (6) tick();
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        check("yq_empty", yq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
